// File: rtl/video_timing_controller_if.sv
// Pixel stream from the frame source into the timing controller.
// A beat transfers on a rising clock edge when pixel_valid && pixel_ready; pixel_sof tags the first pixel of a frame.
interface video_timing_controller_if;
   logic [23:0] pixel_data;
   logic        pixel_sof;
   logic        pixel_valid;
   logic        pixel_ready;

   modport master (output pixel_data, output pixel_sof, output pixel_valid, input pixel_ready);
   modport slave  (input pixel_data, input pixel_sof, input pixel_valid, output pixel_ready);
endinterface

// File: rtl/video_timing_controller.sv
// Raster timing generator that feeds a DVI encoder from a frame-aligned valid/ready pixel stream.
// Defining VIDEO_TIMING_PATTERN_EN adds a pattern_mode input selecting a built-in colour-bar source.
module video_timing_controller #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        clear_status,
`ifdef VIDEO_TIMING_PATTERN_EN
   input  logic        pattern_mode,
`endif
   video_timing_controller_if.slave pixel,
   output logic [23:0] video_data,
   output logic        video_de,
   output logic        video_hsync,
   output logic        video_vsync,
   output logic        frame_start,
   output logic        underflow,
   output logic        sync_error,
   output logic [1:0]  debug_state
);
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

   typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN, PATTERN} state_t;

   state_t        state, state_next;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          active, first_pixel, frame_last, in_hsync, in_vsync, running;
   logic          ready, under_set, sync_set;
   logic [23:0]   data_next;

   assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign first_pixel = (h_cnt == '0) && (v_cnt == '0);
   assign frame_last  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
   assign in_hsync    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   assign in_vsync    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
   assign running     = (state != IDLE);
   assign pixel.pixel_ready = ready;
   assign debug_state = state;

`ifdef VIDEO_TIMING_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;
   localparam int BW = $clog2(BAR_W + 1);
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

   logic [BW-1:0] bar_pix;
   logic [2:0]    bar_idx;
   logic [23:0]   bar_colour;

   // Bar position tracks h_cnt and is reloaded as the line wraps so h=0 starts bar 0.
   always_ff @(posedge clock) begin
      if (reset || state == IDLE || h_cnt == H_LAST) begin
         bar_pix <= '0;
         bar_idx <= '0;
      end else if (bar_pix == BAR_LAST) begin
         bar_pix <= '0;
         bar_idx <= bar_idx + 3'd1;
      end else begin
         bar_pix <= bar_pix + 1'b1;
      end
   end

   always_comb begin
      case (bar_idx)
         3'd0:    bar_colour = 24'hFFFFFF;
         3'd1:    bar_colour = 24'hFFFF00;
         3'd2:    bar_colour = 24'h00FFFF;
         3'd3:    bar_colour = 24'h00FF00;
         3'd4:    bar_colour = 24'hFF00FF;
         3'd5:    bar_colour = 24'hFF0000;
         3'd6:    bar_colour = 24'h0000FF;
         default: bar_colour = 24'h000000;
      endcase
   end
`endif

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      data_next  = '0;
      under_set  = 1'b0;
      sync_set   = 1'b0;
      case (state)
         IDLE: begin
            if (enable) state_next = WAIT_SOF;
         end
         WAIT_SOF: begin
            // Non-SOF beats are drained; an SOF beat waits at the head for the frame boundary.
            ready = !(pixel.pixel_valid && pixel.pixel_sof);
         end
         RUN: begin
            ready = active && !(pixel.pixel_valid && pixel.pixel_sof && !first_pixel);
            if (active) begin
               if (!pixel.pixel_valid) begin
                  under_set  = 1'b1;
                  state_next = WAIT_SOF;
               end else if (!ready) begin
                  sync_set   = 1'b1;
                  state_next = WAIT_SOF;
               end else begin
                  data_next = pixel.pixel_data;
                  if (first_pixel && !pixel.pixel_sof) begin
                     sync_set   = 1'b1;
                     state_next = WAIT_SOF;
                  end
               end
            end
         end
         default: ;
      endcase
`ifdef VIDEO_TIMING_PATTERN_EN
      if (state == PATTERN && active) data_next = bar_colour;
      if (state == IDLE && enable && pattern_mode) state_next = PATTERN;
`endif
      if (running && frame_last) begin
         if (!enable) state_next = IDLE;
`ifdef VIDEO_TIMING_PATTERN_EN
         else if (pattern_mode) state_next = PATTERN;
         else if (state == PATTERN) state_next = WAIT_SOF;
`endif
         else if (state == WAIT_SOF && pixel.pixel_valid && pixel.pixel_sof) state_next = RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         h_cnt       <= '0;
         v_cnt       <= '0;
         video_data  <= '0;
         video_de    <= 1'b0;
         video_hsync <= ~SYNC_POL;
         video_vsync <= ~SYNC_POL;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
         sync_error  <= 1'b0;
      end else begin
         state <= state_next;
         if (!running) begin
            h_cnt <= '0;
            v_cnt <= '0;
         end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
         video_data  <= data_next;
         video_de    <= running && active;
         video_hsync <= (running && in_hsync) ? SYNC_POL : ~SYNC_POL;
         video_vsync <= (running && in_vsync) ? SYNC_POL : ~SYNC_POL;
         frame_start <= running && first_pixel;
         // A new error in the same cycle as clear_status leaves the flag set.
         underflow   <= under_set | (underflow & ~clear_status);
         sync_error  <= sync_set | (sync_error & ~clear_status);
      end
   end
endmodule

// File: tb/tb_video_timing_controller.sv
// Bench for video_timing_controller on a 14x7 raster: behavioural frame model plus directed literal checks.
module tb_video_timing_controller;
   localparam int HA = 8, HF = 2, HS = 2, HB = 2;
   localparam int VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int TOT = HT * VT;
   localparam bit SYNC_POL = 1'b0;
   localparam int M_OFF = 0, M_HUNT = 1, M_LOCK = 2;

   logic        clock = 1'b0;
   logic        reset, enable, clear_status;
   logic [23:0] video_data;
   logic        video_de, video_hsync, video_vsync, frame_start, underflow, sync_error;
   logic [1:0]  debug_state;
`ifdef VIDEO_TIMING_PATTERN_EN
   logic        pattern_mode = 1'b0;
`endif

   video_timing_controller_if pix();

   video_timing_controller #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_POL(SYNC_POL)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .clear_status(clear_status),
`ifdef VIDEO_TIMING_PATTERN_EN
      .pattern_mode(pattern_mode),
`endif
      .pixel(pix),
      .video_data(video_data),
      .video_de(video_de),
      .video_hsync(video_hsync),
      .video_vsync(video_vsync),
      .frame_start(frame_start),
      .underflow(underflow),
      .sync_error(sync_error),
      .debug_state(debug_state)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   logic [29:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // Source: frames of 32 numbered beats, SOF on index 0.
   logic [23:0] cur_data;
   int          cur_idx, gap_idx, short_at, valid_pct;
   bit          gap_armed, took;
   logic        rst_v, en_v, clr_v;

   task automatic cycle();
      bit gap_fire;
      @(negedge clock);
      if (took) begin
         cur_data = cur_data + 24'd1;
         cur_idx  = (cur_idx == HA * VA - 1) ? 0 : cur_idx + 1;
         if (short_at > 0 && cur_idx == short_at) begin
            cur_idx  = 0;
            short_at = -1;
         end
      end
      reset        = rst_v;
      enable       = en_v;
      clear_status = clr_v;
      gap_fire = gap_armed && (cur_idx == gap_idx);
      if (gap_fire) gap_armed = 1'b0;
      pix.pixel_valid = !gap_fire && ($urandom_range(99) < valid_pct);
      pix.pixel_data  = cur_data;
      pix.pixel_sof   = (cur_idx == 0);
      #1;
      took = pix.pixel_valid && pix.pixel_ready;
   endtask

   // Frame model: position within the frame plus off/hunting/locked mode.
   initial begin : scoreboard
      int mode, pos, h, v;
      bit act, run, rdy, uf, se, mu, ms, modelled, in_hs, in_vs;
      logic [23:0] d;
      logic [29:0] e;
      mode = M_OFF; pos = 0; mu = 0; ms = 0; modelled = 0;
      forever begin
         @(negedge clock);
         #2;
         h = pos % HT;
         v = pos / HT;
         act = (h < HA) && (v < VA);
         if (mode == M_OFF) rdy = 1'b0;
         else if (mode == M_HUNT) rdy = !(pix.pixel_valid && pix.pixel_sof);
         else rdy = act && !(pix.pixel_valid && pix.pixel_sof && pos != 0);
         if (modelled) check("pixel_ready", pix.pixel_ready, rdy);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("video_data", video_data, e[29:6]);
            check("video_de", video_de, e[5]);
            check("video_hsync", video_hsync, e[4]);
            check("video_vsync", video_vsync, e[3]);
            check("frame_start", frame_start, e[2]);
            check("underflow", underflow, e[1]);
            check("sync_error", sync_error, e[0]);
         end
         if (reset) begin
            mode = M_OFF; pos = 0; mu = 0; ms = 0; modelled = 1;
            exp_q.push_back({24'h0, 1'b0, !SYNC_POL, !SYNC_POL, 3'b000});
         end else if (modelled) begin
            run   = (mode != M_OFF);
            in_hs = run && h >= HA + HF && h < HA + HF + HS;
            in_vs = run && v >= VA + VF && v < VA + VF + VS;
            d  = (mode == M_LOCK && act && pix.pixel_valid && rdy) ? pix.pixel_data : 24'h0;
            uf = (mode == M_LOCK) && act && !pix.pixel_valid;
            se = (mode == M_LOCK) && act && pix.pixel_valid && (pix.pixel_sof != (pos == 0));
            mu = uf || (mu && !clear_status);
            ms = se || (ms && !clear_status);
            exp_q.push_back({d, run && act, in_hs ? SYNC_POL : !SYNC_POL,
                             in_vs ? SYNC_POL : !SYNC_POL, run && pos == 0, mu, ms});
            if (mode == M_OFF) begin
               if (enable) mode = M_HUNT;
            end else begin
               if (uf || se) mode = M_HUNT;
               if (pos == TOT - 1) begin
                  if (!enable) mode = M_OFF;
                  else if (mode == M_HUNT && pix.pixel_valid && pix.pixel_sof) mode = M_LOCK;
               end
               pos = (pos + 1) % TOT;
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "time limit");
   end

   initial begin : stimulus
      bit found;
      int de_n, hs_n, vs_n, hs_first, vs_first, fs_extra, n, seq_bad;
      rst_v = 1; en_v = 0; clr_v = 0; valid_pct = 100;
      cur_data = 24'd1; cur_idx = 0; gap_idx = 0; gap_armed = 0; short_at = -1; took = 0;
      reset = 1; enable = 0; clear_status = 0;
      pix.pixel_valid = 0; pix.pixel_data = '0; pix.pixel_sof = 0;
      repeat (3) cycle();
      rst_v = 0;
      cycle();
      check("reset_de", video_de, 1'b0);
      check("reset_hsync", video_hsync, 1'b1);
      check("reset_vsync", video_vsync, 1'b1);
      check("reset_ready", pix.pixel_ready, 1'b0);

      // Raster timing of the first (hunting) frame.
      en_v = 1;
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         cycle();
         found = frame_start;
      end
      check("first_frame_start", found, 1'b1);
      de_n = video_de; hs_n = 0; vs_n = 0; hs_first = -1; vs_first = -1; fs_extra = 0;
      for (int i = 1; i < TOT; i++) begin
         cycle();
         de_n += video_de;
         fs_extra += frame_start;
         if (!video_hsync) begin
            hs_n++;
            if (hs_first < 0) hs_first = i;
         end
         if (!video_vsync) begin
            vs_n++;
            if (vs_first < 0) vs_first = i;
         end
      end
      cycle();
      check("de_per_frame", de_n, 32);
      check("hsync_low_per_frame", hs_n, 14);
      check("vsync_low_per_frame", vs_n, 14);
      check("hsync_offset", hs_first, 10);
      check("vsync_offset", vs_first, 70);
      check("frame_period", frame_start, 1'b1);
      check("no_extra_frame_start", fs_extra, 0);
      check("locked_first_pixel", video_data, 24'h000001);

      // Locked frame carries beats 1..32 in raster order.
      n = 0; seq_bad = 0;
      for (int i = 0; i < TOT; i++) begin
         if (i > 0) cycle();
         if (video_de) begin
            n++;
            if (video_data != 24'(n)) seq_bad++;
         end
      end
      check("locked_seq_count", n, 32);
      check("locked_seq_order", seq_bad, 0);
      check("no_flags", {underflow, sync_error}, 2'b00);

      // Valid drop at pixel 5, then clear.
      gap_idx = 5; gap_armed = 1;
      repeat (2 * TOT) cycle();
      check("underflow_set", underflow, 1'b1);
      check("underflow_no_sync_error", sync_error, 1'b0);
      clr_v = 1;
      cycle();
      clr_v = 0;
      cycle();
      check("underflow_cleared", underflow, 1'b0);

      // SOF arriving on pixel 10.
      short_at = 10;
      repeat (3 * TOT) cycle();
      check("sync_error_set", sync_error, 1'b1);
      check("sync_error_no_underflow", underflow, 1'b0);

      // Disable mid-frame: frame completes, then idle.
      repeat (40) cycle();
      en_v = 0;
      repeat (2 * TOT) cycle();
      check("disabled_de", video_de, 1'b0);
      check("disabled_hsync", video_hsync, 1'b1);
      check("disabled_vsync", video_vsync, 1'b1);
      check("disabled_ready", pix.pixel_ready, 1'b0);

      // Randomized traffic: gaps, stray SOFs, clears, occasional disable.
      en_v = 1; valid_pct = 92;
      repeat (12 * TOT) begin
         clr_v = ($urandom_range(99) < 3);
         if (short_at < 0 && $urandom_range(199) == 0) short_at = $urandom_range(1, 31);
         if ($urandom_range(399) == 0) en_v = !en_v;
         cycle();
      end
      clr_v = 0; en_v = 1;
      repeat ($urandom_range(3, 60)) cycle();

      // Reset mid-line.
      rst_v = 1;
      cycle();
      rst_v = 0;
      cycle();
      check("midreset_de", video_de, 1'b0);
      check("midreset_data", video_data, 24'h0);
      check("midreset_hsync", video_hsync, 1'b1);
      check("midreset_vsync", video_vsync, 1'b1);
      check("midreset_frame_start", frame_start, 1'b0);
      check("midreset_flags", {underflow, sync_error}, 2'b00);
      check("midreset_ready", pix.pixel_ready, 1'b0);
      repeat (4 * TOT) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
